// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Lite programmable AXI-Stream counting-pattern source.
// Each 32-bit lane k of a beat carries SEED + beat_index + k (mod 2^32).
module axis_traffic_gen #(
    parameter int DATA_WIDTH       = 64,
    parameter int STORE_DATA_WIDTH = 4
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          s_axi_control_awvalid,
    output logic                          s_axi_control_awready,
    input  logic [31:0]                   s_axi_control_awaddr,
    input  logic                          s_axi_control_wvalid,
    output logic                          s_axi_control_wready,
    input  logic [STORE_DATA_WIDTH*8-1:0] s_axi_control_wdata,
    input  logic [STORE_DATA_WIDTH-1:0]   s_axi_control_wstrb,
    output logic                          s_axi_control_bvalid,
    input  logic                          s_axi_control_bready,
    output logic [1:0]                    s_axi_control_bresp,
    input  logic                          s_axi_control_arvalid,
    output logic                          s_axi_control_arready,
    input  logic [31:0]                   s_axi_control_araddr,
    output logic                          s_axi_control_rvalid,
    input  logic                          s_axi_control_rready,
    output logic [STORE_DATA_WIDTH*8-1:0] s_axi_control_rdata,
    output logic [1:0]                    s_axi_control_rresp,
    output logic [DATA_WIDTH*8-1:0]       outstream_tdata,
    output logic                          outstream_tvalid,
    input  logic                          outstream_tready
);

    localparam int LANES = DATA_WIDTH / 4;

    localparam logic [31:0] ADDR_CONTROL    = 32'd16;
    localparam logic [31:0] ADDR_BEAT_COUNT = 32'd20;
    localparam logic [31:0] ADDR_GAP        = 32'd24;
    localparam logic [31:0] ADDR_SEED       = 32'd28;
    localparam logic [31:0] ADDR_SENT_LO    = 32'd32;
    localparam logic [31:0] ADDR_SENT_HI    = 32'd36;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0] beat_count;
    logic [31:0] gap_reg;
    logic [31:0] seed_reg;
    logic [63:0] sent;
    logic [31:0] sent_shadow;
    logic [31:0] index;
    logic [31:0] gap_cnt;
    logic        stop_pend;
    logic        clear_pend;

    logic        wr_en;
    logic        ar_hs;
    logic        cmd_write;
    logic        cmd_stop;
    logic        cmd_start;
    logic        cmd_clear;
    logic        hs;
    logic        last_beat;
    logic        halt;
    logic        do_clear;
    logic        load_beat;
    logic [31:0] load_idx;
    logic [DATA_WIDTH*8-1:0] beat_data;
    logic [31:0] read_mux;
    logic        busy;
    logic        done;

    // Byte-enable merge used by the writable configuration registers.
    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign wr_en  = ~s_axi_control_bvalid & s_axi_control_awvalid & s_axi_control_wvalid;
    assign ar_hs  = s_axi_control_arvalid & ~s_axi_control_rvalid;

    assign s_axi_control_awready = wr_en;
    assign s_axi_control_wready  = wr_en;
    assign s_axi_control_arready = ~s_axi_control_rvalid;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_rresp   = 2'b00;

    assign cmd_write = wr_en && (s_axi_control_awaddr == ADDR_CONTROL) && s_axi_control_wstrb[0];
    assign cmd_stop  = cmd_write && (s_axi_control_wdata == 32'd0);
    assign cmd_start = cmd_write && (s_axi_control_wdata == 32'd1);
    assign cmd_clear = cmd_write && (s_axi_control_wdata == 32'd2);

    // tvalid comes straight from the state register so an async reset drops it at once.
    assign outstream_tvalid = (state == S_SEND);
    assign hs        = outstream_tvalid & outstream_tready;
    assign last_beat = (beat_count != 32'd0) && ((index + 32'd1) == beat_count);
    assign halt      = stop_pend | clear_pend | cmd_stop | cmd_clear;
    assign busy      = (state == S_SEND) || (state == S_GAP);
    assign done      = (state == S_DONE);

    // Clear takes effect immediately when no beat is on the bus, else after the held beat is accepted.
    assign do_clear = (cmd_clear && (state != S_SEND)) ||
                      ((state == S_SEND) && hs && (clear_pend || cmd_clear));

    // Next-state logic and selection of which beat (if any) to load into tdata.
    always_comb begin
        state_nxt = state;
        load_beat = 1'b0;
        load_idx  = index;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    state_nxt = S_SEND;
                    load_beat = 1'b1;
                    load_idx  = 32'd0;
                end
            end
            S_DONE: begin
                if (cmd_start) begin
                    state_nxt = S_SEND;
                    load_beat = 1'b1;
                    load_idx  = 32'd0;
                end else if (cmd_clear) begin
                    state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (halt) begin
                        state_nxt = S_IDLE;
                    end else if (last_beat) begin
                        state_nxt = S_DONE;
                    end else if (gap_reg != 32'd0) begin
                        state_nxt = S_GAP;
                    end else begin
                        load_beat = 1'b1;
                        load_idx  = index + 32'd1;
                    end
                end
            end
            S_GAP: begin
                if (cmd_stop || cmd_clear) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt <= 32'd1) begin
                    state_nxt = S_SEND;
                    load_beat = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane pattern for the beat about to be presented, using the current seed.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_data[k*32 +: 32] = seed_reg + load_idx + 32'(k);
        end
    end

    // State register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat datapath: index, sent counter, gap counter, held tdata and pending stop/clear.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            index           <= '0;
            sent            <= '0;
            gap_cnt         <= '0;
            stop_pend       <= 1'b0;
            clear_pend      <= 1'b0;
            outstream_tdata <= '0;
        end else begin
            if (do_clear) begin
                index <= '0;
                sent  <= '0;
            end else begin
                if (cmd_start && ((state == S_IDLE) || (state == S_DONE))) begin
                    index <= '0;
                end else if (hs) begin
                    index <= index + 32'd1;
                end
                if (hs) begin
                    sent <= sent + 64'd1;
                end
            end

            if ((state == S_SEND) && (state_nxt == S_GAP)) begin
                gap_cnt <= gap_reg;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 32'd1;
            end

            if ((state != S_SEND) || hs) begin
                stop_pend  <= 1'b0;
                clear_pend <= 1'b0;
            end else begin
                if (cmd_stop) begin
                    stop_pend <= 1'b1;
                end
                if (cmd_clear) begin
                    clear_pend <= 1'b1;
                end
            end

            if (load_beat) begin
                outstream_tdata <= beat_data;
            end
        end
    end

    // Configuration registers and write response channel.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            beat_count           <= '0;
            gap_reg              <= '0;
            seed_reg             <= '0;
            s_axi_control_bvalid <= 1'b0;
        end else begin
            if (wr_en) begin
                s_axi_control_bvalid <= 1'b1;
                case (s_axi_control_awaddr)
                    ADDR_BEAT_COUNT: beat_count <= merge(beat_count, s_axi_control_wdata, s_axi_control_wstrb);
                    ADDR_GAP:        gap_reg    <= merge(gap_reg, s_axi_control_wdata, s_axi_control_wstrb);
                    ADDR_SEED:       seed_reg   <= merge(seed_reg, s_axi_control_wdata, s_axi_control_wstrb);
                    default: ;
                endcase
            end else if (s_axi_control_bready) begin
                s_axi_control_bvalid <= 1'b0;
            end
        end
    end

    // Read address decode.
    always_comb begin
        read_mux = 32'h0000DEAD;
        case (s_axi_control_araddr)
            ADDR_CONTROL:    read_mux = {30'b0, done, busy};
            ADDR_BEAT_COUNT: read_mux = beat_count;
            ADDR_GAP:        read_mux = gap_reg;
            ADDR_SEED:       read_mux = seed_reg;
            ADDR_SENT_LO:    read_mux = sent[31:0];
            ADDR_SENT_HI:    read_mux = sent_shadow;
            default:         read_mux = 32'h0000DEAD;
        endcase
    end

    // Registered read channel; a SENT_LO read snapshots the high word for a tear-free pair.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s_axi_control_rvalid <= 1'b0;
            s_axi_control_rdata  <= '0;
            sent_shadow          <= '0;
        end else begin
            if (ar_hs) begin
                s_axi_control_rvalid <= 1'b1;
                s_axi_control_rdata  <= read_mux;
                if (s_axi_control_araddr == ADDR_SENT_LO) begin
                    sent_shadow <= sent[63:32];
                end
            end else if (s_axi_control_rready) begin
                s_axi_control_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: scoreboard bench for the AXI-Stream traffic generator.
module tb_axis_traffic_gen;

    localparam int DW    = 64;
    localparam int TW    = DW * 8;
    localparam int LANES = DW / 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic [TW-1:0] tdata;
    logic          tvalid, tready;

    int checks = 0;
    int errors = 0;
    logic [TW-1:0] exp_q[$];

    axis_traffic_gen #(.DATA_WIDTH(DW), .STORE_DATA_WIDTH(4)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
        .s_axi_control_awaddr(awaddr),
        .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
        .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
        .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
        .s_axi_control_bresp(bresp),
        .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
        .s_axi_control_araddr(araddr),
        .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
        .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
        .outstream_tdata(tdata), .outstream_tvalid(tvalid), .outstream_tready(tready)
    );

    // Free-running clock.
    always #5 ap_clk = ~ap_clk;

    // Hard stop if something wedges beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [TW-1:0] exp_beat(input logic [31:0] seed, input logic [31:0] idx);
        logic [TW-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[k*32 +: 32] = seed + idx + 32'(k);
        return v;
    endfunction

    task automatic push_beats(input logic [31:0] seed, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_beat(seed, 32'(i)));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!awready && n < 20) begin @(negedge ap_clk); n++; end
        if (!awready) begin
            checks++; errors++;
            $display("[TB] FAIL axi_write_accept: addr %h not accepted within 20 cycles", a);
        end
        @(posedge ap_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        @(negedge ap_clk);
        while (!bvalid && n < 20) begin @(negedge ap_clk); n++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("[TB] FAIL axi_write_resp: no bvalid for addr %h within 20 cycles", a);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        d = 32'hX;
        araddr = a; arvalid = 1'b1;
        n = 0;
        @(negedge ap_clk);
        while (!arready && n < 20) begin @(negedge ap_clk); n++; end
        if (!arready) begin
            checks++; errors++;
            $display("[TB] FAIL axi_read_accept: addr %h not accepted within 20 cycles", a);
        end
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge ap_clk);
        while (!rvalid && n < 20) begin @(negedge ap_clk); n++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("[TB] FAIL axi_read_data: no rvalid for addr %h within 20 cycles", a);
        end else begin
            d = rdata;
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [6];
        logic [31:0] rd;
        addrs = '{32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36};
        ap_rst = 1'b1;
        awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0; wstrb = 0; bready = 1'b1;
        arvalid = 0; araddr = 0; rready = 1'b1; tready = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b0 || tdata !== '0 || bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: tvalid=%b tdata_lo=%h bvalid=%b rvalid=%b rdata=%h, expected all 0",
                     tvalid, tdata[63:0], bvalid, rvalid, rdata);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            axi_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_reg_%0d: got %h, expected %h", addrs[i], rd, 32'h0);
            end
        end
        axi_read(32'd40, rd);
        checks++;
        if (rd !== 32'h0000DEAD) begin
            errors++;
            $display("[TB] FAIL reset_unmapped: got %h, expected %h", rd, 32'h0000DEAD);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] rd;
        axi_write(32'd28, 32'hAABBCCDD, 4'b1111);
        axi_write(32'd28, 32'h11223344, 4'b0101);
        axi_read(32'd28, rd);
        checks++;
        if (rd !== 32'hAA22CC44) begin
            errors++;
            $display("[TB] FAIL wstrb_seed: got %h, expected %h", rd, 32'hAA22CC44);
        end
        axi_write(32'd16, 32'd1, 4'b1110);
        axi_write(32'd32, 32'h55, 4'b1111);
        axi_write(32'd64, 32'h77, 4'b1111);
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h0 || tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wstrb_control_ignored: control=%h tvalid=%b, expected 0 and 0", rd, tvalid);
        end
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL readonly_sent_lo: got %h, expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_finite_burst();
        logic [31:0] rd;
        logic [TW-1:0] e;
        exp_q.delete();
        axi_write(32'd28, 32'h100, 4'hF);
        axi_write(32'd20, 32'd4, 4'hF);
        axi_write(32'd24, 32'd0, 4'hF);
        tready = 1'b0;
        axi_write(32'd16, 32'd1, 4'hF);
        push_beats(32'h100, 4);
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL burst_busy: got %h, expected %h", rd, 32'h1);
        end
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || tdata !== e) begin
                errors++;
                $display("[TB] FAIL burst_beat%0d: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                         i, tvalid, tdata[63:0], e[63:0]);
            end
            @(posedge ap_clk); #1;
        end
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_end_valid: got %b, expected 0", tvalid);
        end
        @(posedge ap_clk); #1;
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL burst_control_done: got %h, expected %h", rd, 32'h2);
        end
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'd4) begin
            errors++;
            $display("[TB] FAIL burst_sent_lo: got %h, expected %h", rd, 32'd4);
        end
    endtask

    task automatic test_gap_timing();
        logic [31:0] rd;
        logic [7:0] pat;
        logic [TW-1:0] e;
        pat = 8'b0100_1001;
        exp_q.delete();
        axi_write(32'd28, 32'h500, 4'hF);
        axi_write(32'd20, 32'd3, 4'hF);
        axi_write(32'd24, 32'd2, 4'hF);
        tready = 1'b0;
        axi_write(32'd16, 32'd1, 4'hF);
        push_beats(32'h500, 3);
        tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            checks++;
            if (tvalid !== pat[c]) begin
                errors++;
                $display("[TB] FAIL gap_valid_cycle%0d: got %b, expected %b", c, tvalid, pat[c]);
            end
            if (pat[c]) begin
                e = exp_q.pop_front();
                checks++;
                if (tdata !== e) begin
                    errors++;
                    $display("[TB] FAIL gap_data_cycle%0d: got %h, expected %h", c, tdata[63:0], e[63:0]);
                end
            end
            @(posedge ap_clk); #1;
        end
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("[TB] FAIL gap_control_done: got %h, expected %h", rd, 32'h2);
        end
    endtask

    task automatic test_backpressure_stop();
        logic [31:0] rd;
        logic [3:0] tpat;
        int accepted;
        tpat = 4'b1001;
        accepted = 0;
        exp_q.delete();
        axi_write(32'd16, 32'd2, 4'hF);
        axi_write(32'd28, 32'h2000, 4'hF);
        axi_write(32'd20, 32'd0, 4'hF);
        axi_write(32'd24, 32'd0, 4'hF);
        tready = 1'b0;
        axi_write(32'd16, 32'd1, 4'hF);
        push_beats(32'h2000, 40);
        for (int c = 0; c < 12; c++) begin
            tready = tpat[c % 4];
            @(negedge ap_clk);
            checks++;
            if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
                errors++;
                $display("[TB] FAIL bp_beat_cycle%0d: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                         c, tvalid, tdata[63:0], exp_q[0][63:0]);
            end
            if (tready) begin
                void'(exp_q.pop_front());
                accepted++;
            end
            @(posedge ap_clk); #1;
        end
        tready = 1'b0;
        axi_write(32'd16, 32'd0, 4'hF);
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL bp_stall_hold: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                     tvalid, tdata[63:0], exp_q[0][63:0]);
        end
        @(posedge ap_clk); #1;
        tready = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL bp_final_beat: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                     tvalid, tdata[63:0], exp_q[0][63:0]);
        end
        void'(exp_q.pop_front());
        accepted++;
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_stopped_valid: got %b, expected 0", tvalid);
        end
        @(posedge ap_clk); #1;
        tready = 1'b0;
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL bp_control_idle: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'(accepted) || accepted != 7) begin
            errors++;
            $display("[TB] FAIL bp_sent_lo: got %0d, expected %0d (bench counted %0d)", rd, 7, accepted);
        end
        exp_q.delete();
    endtask

    task automatic test_clear();
        logic [31:0] rd;
        logic [TW-1:0] e;
        exp_q.delete();
        axi_write(32'd16, 32'd2, 4'hF);
        axi_write(32'd28, 32'h300, 4'hF);
        axi_write(32'd20, 32'd10, 4'hF);
        axi_write(32'd24, 32'd0, 4'hF);
        tready = 1'b0;
        axi_write(32'd16, 32'd1, 4'hF);
        push_beats(32'h300, 10);
        tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            e = exp_q.pop_front();
            checks++;
            if (tvalid !== 1'b1 || tdata !== e) begin
                errors++;
                $display("[TB] FAIL clear_beat%0d: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                         i, tvalid, tdata[63:0], e[63:0]);
            end
            @(posedge ap_clk); #1;
        end
        tready = 1'b0;
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'd10) begin
            errors++;
            $display("[TB] FAIL clear_sent_before: got %h, expected %h", rd, 32'd10);
        end
        axi_write(32'd16, 32'd2, 4'hF);
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL clear_control_idle: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL clear_sent_lo: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd36, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL clear_sent_hi: got %h, expected %h", rd, 32'h0);
        end
        axi_write(32'd16, 32'd1, 4'hF);
        e = exp_beat(32'h300, 32'd0);
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== e) begin
            errors++;
            $display("[TB] FAIL clear_restart: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                     tvalid, tdata[63:0], e[63:0]);
        end
        @(posedge ap_clk); #1;
        axi_write(32'd16, 32'd0, 4'hF);
        tready = 1'b1;
        @(posedge ap_clk); #1;
        tready = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_restart_stop: got valid=%b, expected 0", tvalid);
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_sent_snapshot();
        logic [31:0] rd;
        logic [TW-1:0] e;
        axi_write(32'd20, 32'd1, 4'hF);
        axi_write(32'd24, 32'd0, 4'hF);
        axi_write(32'd28, 32'h7, 4'hF);
        tready = 1'b0;
        @(negedge ap_clk);
        force dut.sent = 64'h0000_0000_FFFF_FFFF;
        @(posedge ap_clk); #1;
        release dut.sent;
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL snap_sent_lo_pre: got %h, expected %h", rd, 32'hFFFFFFFF);
        end
        axi_write(32'd16, 32'd1, 4'hF);
        tready = 1'b1;
        e = exp_beat(32'h7, 32'd0);
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== e) begin
            errors++;
            $display("[TB] FAIL snap_beat: got valid=%b data_lo=%h, expected valid=1 data_lo=%h",
                     tvalid, tdata[63:0], e[63:0]);
        end
        @(posedge ap_clk); #1;
        tready = 1'b0;
        axi_read(32'd36, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL snap_sent_hi_shadow: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd32, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL snap_sent_lo_post: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd36, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("[TB] FAIL snap_sent_hi_post: got %h, expected %h", rd, 32'h1);
        end
    endtask

    task automatic test_reset_midbeat();
        logic [31:0] rd;
        axi_write(32'd20, 32'd0, 4'hF);
        tready = 1'b0;
        axi_write(32'd16, 32'd1, 4'hF);
        @(negedge ap_clk);
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pre_valid: got %b, expected 1", tvalid);
        end
        #2;
        ap_rst = 1'b1;
        #1;
        checks++;
        if (tvalid !== 1'b0 || tdata !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_async: tvalid=%b tdata_lo=%h, expected 0 and 0", tvalid, tdata[63:0]);
        end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        axi_read(32'd16, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_control: got %h, expected %h", rd, 32'h0);
        end
        axi_read(32'd28, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_seed: got %h, expected %h", rd, 32'h0);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_wstrb();
        test_finite_burst();
        test_gap_timing();
        test_backpressure_stop();
        test_clear();
        test_sent_snapshot();
        test_reset_midbeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
